rnd_gen_multi: RTL and testbench

Multi-channel, parametrised Galois LFSR random source with seed reload, post-seed warm-up and per-channel range-limited draws by rejection sampling. It delivers one vector of `CHANNELS` random lanes per valid/ready handshake. It sits between the seed/control logic and consumers that need bounded random values, such as display buffers and test-pattern generators.

---
 rtl/rnd_gen_multi.sv | 144 ++++++++++++++
 tb/tb_rnd_gen_multi.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnd_gen_multi.sv
// Multi-lane Galois LFSR random source: seed reload, post-seed warm-up and
// per-lane bounded draws by rejection sampling behind a valid/ready output.
module rnd_gen_multi #(
    parameter int                WIDTH    = 16,
    parameter logic [WIDTH-1:0]  TAPS     = 16'hB400,
    parameter int                CHANNELS = 2,
    parameter int                WARMUP   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         seed_load,
    input  logic [WIDTH-1:0]             seed,
    input  logic [WIDTH-1:0]             limit,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [CHANNELS*WIDTH-1:0]    out_data,
    output logic                         busy
);

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int               CNT_W      = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam state_e           INIT_STATE = (WARMUP > 0) ? ST_WARM : ST_RUN;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // Fills every bit below the most significant set bit.
    function automatic logic [WIDTH-1:0] smear(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v;
        for (int sh = 1; sh < WIDTH; sh = sh * 2) begin
            r = r | (r >> sh);
        end
        return r;
    endfunction

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]      s_q    [CHANNELS];
    logic [WIDTH-1:0]      s_d    [CHANNELS];
    logic [WIDTH-1:0]      lane_q [CHANNELS];
    logic [WIDTH-1:0]      lane_d [CHANNELS];
    logic [CHANNELS-1:0]   hit_q, hit_d;

    logic [WIDTH-1:0]      seed_val [CHANNELS];
    logic [WIDTH-1:0]      cand     [CHANNELS];
    logic [CHANNELS-1:0]   accept;
    logic [WIDTH-1:0]      mask;
    logic                  fire;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            seed_val[i] = seed + WIDTH'(i);
            if (seed_val[i] == '0) begin
                seed_val[i] = {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // limit == 1 smears to zero, so every candidate collapses to 0 and is accepted.
    assign mask = smear(limit - {{(WIDTH-1){1'b0}}, 1'b1});

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cand[i]   = (limit == '0) ? s_q[i] : (s_q[i] & mask);
            accept[i] = (limit == '0) || (cand[i] < limit);
        end
    end

    assign out_valid = (state_q == ST_RUN) && (&hit_q);
    assign busy      = (state_q == ST_WARM);
    assign fire      = out_valid && out_ready;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            out_data[i*WIDTH +: WIDTH] = lane_q[i];
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        lane_d  = lane_q;
        s_d     = s_q;

        if (seed_load) begin
            state_d = INIT_STATE;
            cnt_d   = '0;
            hit_d   = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                s_d[i]    = seed_val[i];
                lane_d[i] = '0;
            end
        end else if (state_q == ST_WARM) begin
            for (int i = 0; i < CHANNELS; i++) begin
                s_d[i] = lfsr_step(s_q[i]);
            end
            if (cnt_q == CNT_LAST) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            // A lane that already hit waits for the handshake; the others retry each cycle.
            for (int i = 0; i < CHANNELS; i++) begin
                if (!hit_q[i] || fire) begin
                    lane_d[i] = cand[i];
                    hit_d[i]  = accept[i];
                    s_d[i]    = lfsr_step(s_q[i]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= INIT_STATE;
            cnt_q   <= '0;
            hit_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                s_q[i]    <= seed_val[i];
                lane_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            s_q     <= s_d;
            lane_q  <= lane_d;
        end
    end

endmodule

// File: tb/tb_rnd_gen_multi.sv
// Self-checking bench for rnd_gen_multi: a 2-lane no-warm-up instance and a
// 1-lane instance with an 8-step warm-up, checked against a stream-level model.
module tb_rnd_gen_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Two-lane instance, no warm-up
    logic        a_rst, a_seed_load, a_ready;
    logic [7:0]  a_seed, a_limit;
    logic        a_valid, a_busy;
    logic [15:0] a_data;

    // One-lane instance, 8-step warm-up
    logic        b_rst, b_seed_load, b_ready;
    logic [7:0]  b_seed, b_limit;
    logic        b_valid, b_busy;
    logic [7:0]  b_data;

    rnd_gen_multi #(.WIDTH(8), .TAPS(8'hB8), .CHANNELS(2), .WARMUP(0)) u_dut_a (
        .clk       (clk),
        .rst       (a_rst),
        .seed_load (a_seed_load),
        .seed      (a_seed),
        .limit     (a_limit),
        .out_ready (a_ready),
        .out_valid (a_valid),
        .out_data  (a_data),
        .busy      (a_busy)
    );

    rnd_gen_multi #(.WIDTH(8), .TAPS(8'hB8), .CHANNELS(1), .WARMUP(8)) u_dut_b (
        .clk       (clk),
        .rst       (b_rst),
        .seed_load (b_seed_load),
        .seed      (b_seed),
        .limit     (b_limit),
        .out_ready (b_ready),
        .out_valid (b_valid),
        .out_data  (b_data),
        .busy      (b_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream-level reference: each lane's delivered values are the accepted
    // candidates of its own LFSR sequence, in order.
    logic [7:0] m_s [2];
    logic [7:0] m_lim;

    function automatic logic [7:0] lstep(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    task automatic model_seed(input logic [7:0] sd);
        for (int i = 0; i < 2; i++) begin
            m_s[i] = sd + 8'(i);
            if (m_s[i] == 8'h00) m_s[i] = 8'h01;
        end
    endtask

    task automatic model_draw(output logic [15:0] v);
        int         bl;
        logic [7:0] m;
        logic [7:0] c;
        bl = 0;
        while ((1 << bl) < int'(m_lim)) bl++;
        m = 8'((1 << bl) - 1);
        v = '0;
        c = '0;
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 1000; n++) begin
                c = (m_lim == 8'h00) ? m_s[i] : (m_s[i] & m);
                m_s[i] = lstep(m_s[i]);
                if (m_lim == 8'h00 || c < m_lim) break;
            end
            v[i*8 +: 8] = c;
        end
    endtask

    task automatic run_seg(input logic [7:0] sd, input logic [7:0] lim, input int n_hs, input int ready_pct);
        logic [15:0] expv;
        bit          have;
        int          hs;
        expv = '0;
        have = 1'b0;
        hs   = 0;
        a_seed      = sd;
        a_limit     = lim;
        a_seed_load = 1'b1;
        a_ready     = 1'($urandom);
        tick();
        a_seed_load = 1'b0;
        check("seg_load_valid", a_valid, 0);
        model_seed(sd);
        m_lim = lim;
        for (int cyc = 0; cyc < n_hs * 20 + 50 && hs < n_hs; cyc++) begin
            a_ready = ($urandom_range(99) < ready_pct);
            if (lim == 8'h00 && cyc >= 1) check("seg_fullrate_valid", a_valid, 1);
            if (a_valid) begin
                if (!have) begin
                    model_draw(expv);
                    have = 1'b1;
                end
                check("seg_data", a_data, expv);
                if (a_ready) begin
                    have = 1'b0;
                    hs++;
                end
            end
            tick();
        end
        check("seg_handshakes", hs, n_hs);
    endtask

    typedef struct {
        logic [7:0]  seed;
        logic [7:0]  limit;
        logic [15:0] v0;
        logic [15:0] v1;
        logic [15:0] v2;
    } vec_t;

    vec_t tbl [6];

    logic        seen [256];
    int          distinct;
    logic [7:0]  m_b;
    logic [7:0]  first_b;

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'h01, 8'h00, 16'h0201, 16'h01B8, 16'hB85C};
        tbl[1] = '{8'h00, 8'h00, 16'h0101, 16'hB8B8, 16'h5C5C};
        tbl[2] = '{8'hFF, 8'h00, 16'h01FF, 16'hB8C7, 16'h5CDB};
        tbl[3] = '{8'h7F, 8'h00, 16'h807F, 16'h4087, 16'h20FB};
        tbl[4] = '{8'h80, 8'h01, 16'h0000, 16'h0000, 16'h0000};
        tbl[5] = '{8'h01, 8'h02, 16'h0001, 16'h0100, 16'h0000};

        a_rst = 1'b1; a_seed_load = 1'b0; a_seed = 8'h01; a_limit = 8'h00; a_ready = 1'b1;
        b_rst = 1'b1; b_seed_load = 1'b0; b_seed = 8'h01; b_limit = 8'h00; b_ready = 1'b1;
        tick();
        b_rst = 1'b0;

        // Reset-to-first-vectors table, full-rate consumer
        for (int k = 0; k < 6; k++) begin
            a_seed  = tbl[k].seed;
            a_limit = tbl[k].limit;
            a_ready = 1'b1;
            a_rst   = 1'b1;
            tick();
            a_rst = 1'b0;
            check("tbl_reset_valid", a_valid, 0);
            check("tbl_reset_data", a_data, 0);
            check("tbl_busy", a_busy, 0);
            tick();
            check("tbl_v0_valid", a_valid, 1);
            check("tbl_v0", a_data, tbl[k].v0);
            tick();
            check("tbl_v1_valid", a_valid, 1);
            check("tbl_v1", a_data, tbl[k].v1);
            tick();
            check("tbl_v2", a_data, tbl[k].v2);
        end

        // Backpressure: vector and lane states frozen, limit change ignored while held
        a_seed = 8'h01; a_limit = 8'h00; a_ready = 1'b0; a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        tick();
        check("bp_first", a_data, 16'h0201);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_valid", a_valid, 1);
            check("bp_hold_data", a_data, 16'h0201);
        end
        a_limit = 8'h03;
        tick();
        check("bp_limit_change_data", a_data, 16'h0201);
        a_limit = 8'h00;
        a_ready = 1'b1;
        tick();
        check("bp_release_data", a_data, 16'h01B8);

        // seed_load while valid, with a coincident handshake that must be ignored
        a_seed = 8'h01; a_seed_load = 1'b1; a_ready = 1'b1;
        tick();
        a_seed_load = 1'b0;
        check("reload_drop_valid", a_valid, 0);
        tick();
        check("reload_v0", a_data, 16'h0201);
        tick();
        check("reload_v1", a_data, 16'h01B8);

        // seed_load while held under backpressure
        a_ready = 1'b0;
        tick();
        check("reload_bp_held", a_valid, 1);
        a_seed = 8'h00; a_seed_load = 1'b1;
        tick();
        a_seed_load = 1'b0;
        check("reload_bp_valid", a_valid, 0);
        a_ready = 1'b1;
        tick();
        check("reload_bp_v0", a_data, 16'h0101);

        // Warm-up instance: 8 busy cycles, first vector one cycle after RUN
        b_seed = 8'h01; b_limit = 8'h00; b_ready = 1'b1; b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("warm_busy", b_busy, 1);
            check("warm_no_valid", b_valid, 0);
            tick();
        end
        check("warm_done_busy", b_busy, 0);
        check("warm_done_valid", b_valid, 0);
        tick();
        m_b = 8'h01;
        repeat (8) m_b = lstep(m_b);
        check("warm_first_hand", b_data, 8'h64);

        // Full period of the single lane
        for (int v = 0; v < 256; v++) seen[v] = 1'b0;
        distinct = 0;
        first_b  = b_data;
        for (int k = 0; k < 255; k++) begin
            check("period_valid", b_valid, 1);
            check("period_data", b_data, m_b);
            if (!seen[b_data]) distinct++;
            seen[b_data] = 1'b1;
            m_b = lstep(m_b);
            tick();
        end
        check("period_distinct", distinct, 255);
        check("period_no_zero", seen[0], 0);
        check("period_repeat", b_data, first_b);

        // Randomized segments against the stream model
        run_seg(8'($urandom), 8'h03, 1000, 80);
        run_seg(8'($urandom), 8'h00, 200, 70);
        run_seg(8'($urandom), 8'h01, 50, 60);
        run_seg(8'($urandom), 8'h02, 100, 75);
        for (int k = 0; k < 4; k++) begin
            run_seg(8'($urandom), 8'($urandom), 150, 70);
        end
        run_seg(8'h00, 8'hC8, 150, 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
